// File: rtl/s_bdq_act.sv
// Streaming activation dequantizer: re-expands 8-bit sigmoid/tanh LUT codes into the
// signed 32-bit accumulator domain through a two-stage valid/ready pipeline with element counting.
module s_bdq_act #(
    parameter logic [9:0] SCALE_DATA        = 10'd128,
    parameter logic [9:0] SCALE_W           = 10'd128,
    parameter logic [9:0] OUT_SCALE_SIGMOID = 10'd256,
    parameter logic [9:0] OUT_SCALE_TANH    = 10'd128,
    parameter logic [7:0] OUT_ZERO_SIGMOID  = 8'd0,
    parameter logic [7:0] OUT_ZERO_TANH     = 8'd128,
    parameter logic [7:0] VEC_LEN           = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_mode,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        len_err,
    output logic        vec_done
);

    localparam logic signed [31:0] ACC_SCALE = 32'(SCALE_W) * 32'(SCALE_DATA);
    localparam logic signed [31:0] DIV_S     = 32'(OUT_SCALE_SIGMOID);
    localparam logic signed [31:0] DIV_T     = 32'(OUT_SCALE_TANH);

    // Signed division truncates toward zero, which is exactly the required rounding.
    function automatic logic signed [31:0] dequant(input logic signed [8:0] d, input logic mode);
        logic signed [31:0] prod;
        logic signed [31:0] div;
        prod = 32'(d) * ACC_SCALE;
        div  = mode ? DIV_T : DIV_S;
        return prod / div;
    endfunction

    logic signed [8:0]  d_in;
    logic [7:0]         zero_sel;
    logic               accept;
    logic               s1_adv;
    logic               s2_adv;
    logic               at_end;
    logic [7:0]         cnt;

    logic               vld_p1;
    logic signed [8:0]  d_p1;
    logic               mode_p1;
    logic               last_p1;

    logic               vld_p2;
    logic signed [31:0] data_p2;
    logic               last_p2;

    assign zero_sel = in_mode ? OUT_ZERO_TANH : OUT_ZERO_SIGMOID;
    assign d_in     = $signed({1'b0, in_data}) - $signed({1'b0, zero_sel});

    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = vld_p1 && s2_adv;
    assign in_ready = !vld_p1 || s2_adv;
    assign accept   = in_valid && in_ready;
    assign at_end   = (cnt == VEC_LEN - 8'd1);

    assign out_valid = vld_p2;
    assign out_data  = vld_p2 ? data_p2 : 32'sd0;
    assign out_last  = vld_p2 && last_p2;
    assign vec_done  = vld_p2 && out_ready && last_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            cnt     <= 8'd0;
            len_err <= 1'b0;
        end else begin
            if (in_ready) vld_p1 <= in_valid;
            if (s2_adv) vld_p2 <= vld_p1;
            if (accept) begin
                cnt <= at_end ? 8'd0 : cnt + 8'd1;
                if (in_last != at_end) len_err <= 1'b1;
            end
        end
    end

    // Stage 1: zero-point removal, mode and counter-derived last captured with the sample
    always_ff @(posedge clk) begin
        if (accept) begin
            d_p1    <= d_in;
            mode_p1 <= in_mode;
            last_p1 <= at_end;
        end
    end

    // Stage 2: rescale into the accumulator domain
    always_ff @(posedge clk) begin
        if (s1_adv) begin
            data_p2 <= dequant(d_p1, mode_p1);
            last_p2 <= last_p1;
        end
    end

endmodule

// File: tb/tb_s_bdq_act.sv
// Scoreboard bench for s_bdq_act: randomized and directed stimulus checked against
// a plain-arithmetic model of the dequantization and element-count rules.
module tb_s_bdq_act;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        in_mode = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        len_err;
    logic        vec_done;

    s_bdq_act #(.VEC_LEN(8'd4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .len_err(len_err), .vec_done(vec_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int mcnt = 0;
    bit merr = 0;
    int vd_seen = 0;
    int steps = 0;
    bit rand_ordy = 0;
    logic [32:0] sb[$];

    bit          hold = 0;
    logic [31:0] hold_val;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_val(input int q, input bit mode);
        int z;
        int s;
        z = mode ? 128 : 0;
        s = mode ? 128 : 256;
        return ((q - z) * 128 * 128) / s;
    endfunction

    task automatic push(input logic [7:0] q, input logic m, input logic l);
        bit lst;
        lst = (mcnt == 3);
        if (l != lst) merr = 1;
        sb.push_back({lst, 32'(ref_val(int'(q), m))});
        mcnt = (mcnt + 1) % 4;
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            hold = 0;
        end else begin
            if (out_valid) begin
                if (hold) check("stall_hold", out_data, hold_val);
                if (out_ready) begin
                    hold = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", $signed(out_data), $signed(e[31:0]));
                        check("out_last", out_last, e[32]);
                        check("vec_done", vec_done, e[32]);
                        if (vec_done) vd_seen++;
                    end
                end else begin
                    hold = 1;
                    hold_val = out_data;
                end
            end else begin
                hold = 0;
                check("vec_done_idle", vec_done, 0);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] q, input logic m, input logic l,
                        input logic ordy, output bit acc);
        @(posedge clk);
        #1;
        in_valid = v; in_data = q; in_mode = m; in_last = l;
        out_ready = rand_ordy ? ($urandom_range(3) != 0) : ordy;
        steps++;
        @(negedge clk);
        acc = v && in_ready && !rst;
        if (acc) push(q, m, l);
    endtask

    task automatic send(input logic [7:0] q, input logic m, input int force_last);
        bit acc;
        logic l;
        l = (force_last < 0) ? (mcnt == 3) : force_last[0];
        for (int t = 0; t < 200; t++) begin
            step(1'b1, q, m, l, 1'b1, acc);
            if (acc) return;
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 100) begin
            idle(1);
            t++;
        end
        check("drain_timeout", t < 100, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1; in_valid = 0; out_ready = 1;
        sb.delete();
        mcnt = 0;
        merr = 0;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int s0;
        int idx;
        int v0;
        logic [7:0] sd[6];

        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_len_err", len_err, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_vec_done", vec_done, 0);

        // Sigmoid directed values and two-cycle latency
        step(1'b1, 8'd200, 1'b0, 1'b0, 1'b1, acc);
        check("lat_accept", acc, 1);
        idle(1);
        check("lat_cycle1_valid", out_valid, 0);
        idle(1);
        check("lat_cycle2_valid", out_valid, 1);
        check("lat_cycle2_data", $signed(out_data), 12800);
        send(8'd0, 1'b0, -1);
        send(8'd255, 1'b0, -1);
        drain();

        // Tanh directed values, then mixed modes back-to-back at full rate
        send(8'd0, 1'b1, -1);
        send(8'd128, 1'b1, -1);
        send(8'd255, 1'b1, -1);
        s0 = steps;
        for (int i = 0; i < 12; i++) send(8'($urandom_range(255)), 1'($urandom_range(1)), -1);
        check("throughput_steps", steps - s0, 12);
        drain();

        // Downstream stall with continuous input
        for (int i = 0; i < 6; i++) sd[i] = 8'($urandom_range(255));
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, sd[idx], 1'b1, (mcnt == 3), 1'b0, acc);
            if (acc) idx++;
        end
        check("stall_accepts", idx, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        while (idx < 6) begin
            send(sd[idx], 1'b1, -1);
            idx++;
        end
        drain();
        check("len_err_clean", len_err, 0);

        // Vector boundaries: two aligned 4-element vectors
        do_reset();
        v0 = vd_seen;
        for (int i = 0; i < 8; i++) send(8'($urandom_range(255)), 1'($urandom_range(1)), -1);
        drain();
        check("vec_done_count", vd_seen - v0, 2);
        check("len_err_aligned", len_err, 0);

        // Randomized stress with gaps and random back-pressure
        rand_ordy = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(4) == 0) idle(1);
            else send(8'($urandom_range(255)), 1'($urandom_range(1)), -1);
        end
        rand_ordy = 0;
        drain();
        check("len_err_stress", len_err, merr);

        // Misplaced in_last: flagged, but the counter still decides out_last
        do_reset();
        send(8'd10, 1'b0, 0);
        send(8'd20, 1'b0, 1);
        send(8'd30, 1'b1, 0);
        send(8'd40, 1'b1, 1);
        drain();
        check("len_err_set", len_err, 1);
        check("model_err_set", merr, 1);
        for (int i = 0; i < 4; i++) send(8'($urandom_range(255)), 1'b0, -1);
        drain();
        check("len_err_sticky", len_err, 1);

        // Reset with both stages full
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 8'($urandom_range(255)), 1'b0, (mcnt == 3), 1'b0, acc);
            if (acc) idx++;
        end
        check("full_before_rst", idx, 2);
        do_reset();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_len_err", len_err, 0);
        v0 = vd_seen;
        for (int i = 0; i < 4; i++) send(8'($urandom_range(255)), 1'($urandom_range(1)), -1);
        drain();
        check("post_rst_vec_done", vd_seen - v0, 1);
        check("post_rst_len_err", len_err, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
